// File: rtl/sram_mem_stage_ctrl.sv
// sram_mem_stage_ctrl
// Memory-stage controller. It takes a load or store request from the EXE->MEM
// register and serves it against an external 16-bit asynchronous SRAM. Each
// 32-bit word is moved as two 16-bit half-accesses: the low half first, then
// the high half. `ready` stays low while a request is in flight so that the
// pipeline stays frozen.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   MEM_R_EN   load request (level, held until ready)
//   MEM_W_EN   store request (level, held until ready); wins over MEM_R_EN
//   ALU_res    byte address
//   ST_val     store data
//   read_data  load result, valid when ready rises for a load, then held
//   ready      high = idle with no request, or request completing
//   SRAM_*     SRAM bus: DQ, half-word address, active-low strobes
module sram_mem_stage_ctrl #(
  parameter int unsigned ADDR_BASE = 1024,
  parameter int unsigned SRAM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_res,
  input  logic [31:0] ST_val,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0]  WAIT_C = 3'(SRAM_WAIT);
  localparam logic [31:0] BASE_C = 32'(ADDR_BASE);

  state_t      state_r, state_s;
  logic [2:0]  cnt_r, cnt_s;
  logic        is_wr_r;
  logic [16:0] word_r;
  logic [31:0] st_val_r;
  logic [31:0] read_data_r;

  logic [31:0] off_s;
  logic [16:0] word_s;
  logic        unused_s;
  logic        last_s;
  logic        hi_s;
  logic        latch_s;
  logic        samp_lo_s;
  logic        samp_hi_s;
  logic        dq_oe_s;
  logic [15:0] dq_out_s;

  // The offset wraps modulo 2^32. Only bits 18:2 select a word, so the
  // byte lane and the bits above the SRAM window are dropped.
  assign off_s    = ALU_res - BASE_C;
  assign word_s   = off_s[18:2];
  assign unused_s = ^{off_s[31:19], off_s[1:0]};

  assign last_s    = (cnt_r == WAIT_C);
  assign hi_s      = (state_r == HIGH);
  assign read_data = read_data_r;
  assign SRAM_DQ   = dq_oe_s ? dq_out_s : 16'bz;

  // State, counter, latched request and load-data registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      is_wr_r     <= 1'b0;
      word_r      <= 17'd0;
      st_val_r    <= 32'd0;
      read_data_r <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (latch_s) begin
        is_wr_r  <= MEM_W_EN;
        word_r   <= word_s;
        st_val_r <= ST_val;
      end
      if (samp_lo_s) begin
        read_data_r[15:0] <= SRAM_DQ;
      end
      if (samp_hi_s) begin
        read_data_r[31:16] <= SRAM_DQ;
      end
    end
  end

  // Next-state logic and SRAM strobe decode. Strobes depend only on
  // registered state, so no input reaches the SRAM pins combinationally.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    latch_s   = 1'b0;
    samp_lo_s = 1'b0;
    samp_hi_s = 1'b0;
    ready     = 1'b0;
    SRAM_ADDR = 18'd0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_CE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    dq_oe_s   = 1'b0;
    dq_out_s  = 16'd0;
    case (state_r)
      IDLE: begin
        ready = ~MEM_R_EN & ~MEM_W_EN;
        if (MEM_R_EN | MEM_W_EN) begin
          latch_s = 1'b1;
          cnt_s   = 3'd0;
          state_s = LOW;
        end else begin
          state_s = IDLE;
        end
      end
      LOW, HIGH: begin
        SRAM_CE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        SRAM_ADDR = {word_r, hi_s};
        if (is_wr_r) begin
          SRAM_WE_N = 1'b0;
          dq_oe_s   = 1'b1;
          dq_out_s  = hi_s ? st_val_r[31:16] : st_val_r[15:0];
        end else begin
          SRAM_OE_N = 1'b0;
        end
        if (last_s) begin
          cnt_s     = 3'd0;
          state_s   = hi_s ? DONE : HIGH;
          // Read data is taken on the final cycle of the half, which gives
          // the SRAM the longest possible settling time.
          samp_lo_s = ~is_wr_r & ~hi_s;
          samp_hi_s = ~is_wr_r & hi_s;
        end else begin
          cnt_s = cnt_r + 3'd1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule
